// File: rtl/afe_tot_meas.sv
// Time-of-arrival / time-over-threshold measurement stage feeding the SPI readout.
// Synchronizes INJ_IN and COMP, measures injection-to-hit and comparator-high intervals.
module afe_tot_meas #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             INJ_IN,
  input  logic             COMP,
  input  logic             RD_ACK,
  output logic             HIT,
  output logic             DATA_VALID,
  output logic [CNT_W-1:0] TOA,
  output logic [CNT_W-1:0] TOT,
  output logic [2:0]       STATUS,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TOT, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] inj_sync_reg;
  logic [SYNC_STAGES-1:0] comp_sync_reg;
  logic                   inj_prev_reg;
  logic                   comp_prev_reg;
  logic                   inj_sync;
  logic                   comp_sync;
  logic                   inj_rise;
  logic                   comp_rise;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] toa_reg, toa_next;
  logic [CNT_W-1:0] tot_reg, tot_next;
  logic [CNT_W-1:0] toa_inc;
  logic [CNT_W-1:0] tot_inc;
  logic [2:0]       status_reg, status_next;
  logic             hit_reg, dv_reg, busy_reg;

  // Identical depth on both paths so synchronizer latency cancels out of TOA.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      inj_sync_reg  <= '0;
      comp_sync_reg <= '0;
      inj_prev_reg  <= 1'b0;
      comp_prev_reg <= 1'b0;
    end else begin
      inj_sync_reg  <= {inj_sync_reg[SYNC_STAGES-2:0], INJ_IN};
      comp_sync_reg <= {comp_sync_reg[SYNC_STAGES-2:0], COMP};
      inj_prev_reg  <= inj_sync;
      comp_prev_reg <= comp_sync;
    end
  end

  assign inj_sync  = inj_sync_reg[SYNC_STAGES-1];
  assign comp_sync = comp_sync_reg[SYNC_STAGES-1];
  assign inj_rise  = inj_sync & ~inj_prev_reg;
  assign comp_rise = comp_sync & ~comp_prev_reg;

  assign toa_inc = toa_reg + CNT_W'(1);
  assign tot_inc = tot_reg + CNT_W'(1);

  // TOA doubles as the ARMED interval counter; it is cleared on arming.
  always_comb begin
    state_next  = state_reg;
    toa_next    = toa_reg;
    tot_next    = tot_reg;
    status_next = status_reg;
    case (state_reg)
      S_IDLE: begin
        if (inj_rise) begin
          toa_next = '0;
          tot_next = '0;
          if (comp_sync) begin
            state_next  = S_DONE;
            status_next = 3'b100;
          end else begin
            state_next  = S_ARMED;
            status_next = 3'b000;
          end
        end
      end
      S_ARMED: begin
        toa_next = toa_inc;
        if (comp_rise) begin
          state_next = S_TOT;
          tot_next   = CNT_W'(1);
        end else if (toa_inc == MAX) begin
          state_next     = S_DONE;
          status_next[0] = 1'b1;
        end
      end
      S_TOT: begin
        if (comp_sync) begin
          if (tot_reg != MAX) begin
            tot_next = tot_inc;
            if (tot_inc == MAX) status_next[1] = 1'b1;
          end
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (RD_ACK) begin
          state_next  = S_IDLE;
          status_next = 3'b000;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_reg  <= S_IDLE;
      toa_reg    <= '0;
      tot_reg    <= '0;
      status_reg <= '0;
      hit_reg    <= 1'b0;
      dv_reg     <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      toa_reg    <= toa_next;
      tot_reg    <= tot_next;
      status_reg <= status_next;
      hit_reg    <= (state_next == S_TOT);
      dv_reg     <= (state_next == S_DONE);
      busy_reg   <= (state_next != S_IDLE);
    end
  end

  assign HIT        = hit_reg;
  assign DATA_VALID = dv_reg;
  assign BUSY       = busy_reg;
  assign TOA        = toa_reg;
  assign TOT        = tot_reg;
  assign STATUS     = status_reg;

endmodule

// File: tb/tb_afe_tot_meas.sv
// Randomized self-checking bench for afe_tot_meas; expected results come from interval arithmetic.
`timescale 1ns/1ps
module tb_afe_tot_meas;
  localparam int CNT_W = 8;
  localparam int MAX   = 255;
  localparam int NEVER = 10000;

  logic             CLK = 1'b0;
  logic             RST_B = 1'b1;
  logic             INJ_IN = 1'b0;
  logic             COMP = 1'b0;
  logic             RD_ACK = 1'b0;
  logic             HIT;
  logic             DATA_VALID;
  logic [CNT_W-1:0] TOA;
  logic [CNT_W-1:0] TOT;
  logic [2:0]       STATUS;
  logic             BUSY;

  int checks = 0;
  int errors = 0;

  afe_tot_meas #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_B(RST_B), .INJ_IN(INJ_IN), .COMP(COMP), .RD_ACK(RD_ACK),
    .HIT(HIT), .DATA_VALID(DATA_VALID), .TOA(TOA), .TOT(TOT), .STATUS(STATUS), .BUSY(BUSY)
  );

  always #12.5 CLK = ~CLK;

  // d: COMP rise cycle relative to INJ rise (<=0 means COMP already high), n: COMP high cycles.
  task automatic run_case(input string name, input int d, input int n, input bit extra_inj);
    int exp_toa, exp_tot, exp_st, exp_hits, end_cyc, hits, dv_first;
    bit dv_drop;
    if (d <= 0 && d + n > 0) begin
      exp_toa = 0; exp_tot = 0; exp_st = 4; exp_hits = 0;
    end else if (d >= 1 && d <= MAX) begin
      exp_toa = d; exp_tot = (n >= MAX) ? MAX : n; exp_st = (n >= MAX) ? 2 : 0; exp_hits = n;
    end else begin
      exp_toa = MAX; exp_tot = 0; exp_st = 1; exp_hits = 0;
    end
    end_cyc = 280;
    if (d < NEVER && d + n + 10 > end_cyc) end_cyc = d + n + 10;
    hits = 0; dv_first = -1; dv_drop = 1'b0;
    for (int cyc = -8; cyc < end_cyc; cyc++) begin
      @(posedge CLK); #1;
      INJ_IN = (cyc >= 0 && cyc < 4);
      COMP   = (d < NEVER) && (cyc >= d) && (cyc < d + n);
      @(negedge CLK);
      if (HIT) hits++;
      if (DATA_VALID && dv_first < 0) dv_first = cyc;
      if (!DATA_VALID && dv_first >= 0) dv_drop = 1'b1;
    end
    INJ_IN = 1'b0; COMP = 1'b0;
    checks++; if (dv_first < 0 || dv_drop) begin errors++; $display("FAIL %s dv: first=%0d drop=%0d, required held high", name, dv_first, dv_drop); end
    checks++; if (TOA !== CNT_W'(exp_toa)) begin errors++; $display("FAIL %s toa: got %0d exp %0d", name, TOA, exp_toa); end
    checks++; if (TOT !== CNT_W'(exp_tot)) begin errors++; $display("FAIL %s tot: got %0d exp %0d", name, TOT, exp_tot); end
    checks++; if (STATUS !== 3'(exp_st)) begin errors++; $display("FAIL %s status: got %b exp %b", name, STATUS, 3'(exp_st)); end
    checks++; if (hits != exp_hits) begin errors++; $display("FAIL %s hit_cycles: got %0d exp %0d", name, hits, exp_hits); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL %s busy_done: got %b exp 1", name, BUSY); end
    if (extra_inj) begin
      for (int cyc = 0; cyc < 50; cyc++) begin
        @(posedge CLK); #1;
        INJ_IN = (cyc < 4);
      end
      @(negedge CLK);
      checks++; if (DATA_VALID !== 1'b1 || TOA !== CNT_W'(exp_toa) || TOT !== CNT_W'(exp_tot) || STATUS !== 3'(exp_st)) begin
        errors++; $display("FAIL %s hold: dv=%b toa=%0d tot=%0d st=%b exp dv=1 toa=%0d tot=%0d st=%b",
                           name, DATA_VALID, TOA, TOT, STATUS, exp_toa, exp_tot, 3'(exp_st));
      end
    end
    @(posedge CLK); #1 RD_ACK = 1'b1;
    @(posedge CLK); #1 RD_ACK = 1'b0;
    @(negedge CLK);
    checks++; if (DATA_VALID !== 1'b0 || BUSY !== 1'b0 || STATUS !== 3'b000) begin
      errors++; $display("FAIL %s ack: dv=%b busy=%b st=%b exp 0 0 000", name, DATA_VALID, BUSY, STATUS);
    end
    checks++; if (TOA !== CNT_W'(exp_toa) || TOT !== CNT_W'(exp_tot)) begin
      errors++; $display("FAIL %s ack_keep: toa=%0d tot=%0d exp %0d %0d", name, TOA, TOT, exp_toa, exp_tot);
    end
    $display("case %s d=%0d n=%0d toa=%0d tot=%0d status=%b hit_cycles=%0d", name, d, n, TOA, TOT, STATUS, hits);
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_reset();
    RST_B = 1'b1;
    #3 RST_B = 1'b0;
    #2;
    checks++; if ({HIT, DATA_VALID, BUSY, TOA, TOT, STATUS} !== '0) begin
      errors++; $display("FAIL reset: hit=%b dv=%b busy=%b toa=%0d tot=%0d st=%b exp all 0", HIT, DATA_VALID, BUSY, TOA, TOT, STATUS);
    end
    repeat (3) @(posedge CLK);
    #1 RST_B = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b exp 0", BUSY); end
    $display("case reset busy=%b", BUSY);
  endtask

  task automatic test_directed();
    run_case("hit", 4, 9, 1'b0);
    run_case("timeout", NEVER, 1, 1'b0);
    run_case("overflow", 2, 300, 1'b0);
    run_case("pileup", -3, 10, 1'b0);
    run_case("handshake", 5, 6, 1'b1);
    run_case("after_handshake", 7, 3, 1'b0);
  endtask

  task automatic test_boundaries();
    run_case("toa_min", 1, 1, 1'b0);
    run_case("toa_max_hit", MAX, 3, 1'b0);
    run_case("toa_late", MAX + 1, 4, 1'b0);
    run_case("same_cycle", 0, 5, 1'b0);
  endtask

  task automatic test_reset_mid();
    int busy_seen;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge CLK); #1;
      INJ_IN = (cyc < 4);
      COMP   = (cyc >= 3);
    end
    @(negedge CLK);
    checks++; if (HIT !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: hit=%b exp 1", HIT); end
    @(posedge CLK); #1 RST_B = 1'b0;
    #2;
    checks++; if (HIT !== 1'b0 || DATA_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL rst_mid: hit=%b dv=%b busy=%b exp 0 0 0", HIT, DATA_VALID, BUSY);
    end
    @(posedge CLK); #1 RST_B = 1'b1;
    busy_seen = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge CLK); #1;
      COMP = (cyc < 20);
      @(negedge CLK);
      if (BUSY || HIT || DATA_VALID) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL rst_mid_idle: active cycles %0d exp 0", busy_seen); end
    $display("case reset_mid active_after_release=%0d", busy_seen);
    run_case("post_reset", 6, 8, 1'b0);
  endtask

  task automatic test_random();
    int d, n;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: begin d = $urandom_range(1, 40);    n = $urandom_range(1, 40); end
        1: begin d = $urandom_range(200, 255); n = $urandom_range(1, 20); end
        2: begin d = -$urandom_range(0, 5);    n = -d + $urandom_range(1, 10); end
        default: begin d = $urandom_range(1, 10); n = $urandom_range(256, 280); end
      endcase
      run_case($sformatf("rand%0d", i), d, n, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
